// File: rtl/pwm_multich_dt_if.sv
// Host-side bundle for the multichannel PWM: duty programming, gate outputs and status.
// PWM_FAULT_EN adds the external fault input, its clear and the latched fault flag.
interface pwm_multich_dt_if #(
    parameter int CNT_W = 11,
    parameter int NCH   = 2
);
    logic [NCH*CNT_W-1:0] duty;
    logic [NCH-1:0]       duty_wr;
    logic [NCH-1:0]       duty_pend;
    logic [NCH-1:0]       pwm_hi;
    logic [NCH-1:0]       pwm_lo;
    logic                 PWM_synch;
    logic [NCH-1:0]       ovr_I_blank;
`ifdef PWM_FAULT_EN
    logic                 fault_n;
    logic                 fault_clr;
    logic                 fault_lat;

    modport master (
        output duty, duty_wr, fault_n, fault_clr,
        input  duty_pend, pwm_hi, pwm_lo, PWM_synch, ovr_I_blank, fault_lat
    );
    modport slave (
        input  duty, duty_wr, fault_n, fault_clr,
        output duty_pend, pwm_hi, pwm_lo, PWM_synch, ovr_I_blank, fault_lat
    );
`else
    modport master (
        output duty, duty_wr,
        input  duty_pend, pwm_hi, pwm_lo, PWM_synch, ovr_I_blank
    );
    modport slave (
        input  duty, duty_wr,
        output duty_pend, pwm_hi, pwm_lo, PWM_synch, ovr_I_blank
    );
`endif
endinterface

// File: rtl/pwm_multich_dt.sv
// N-channel complementary edge-aligned PWM with dead time, shadowed duty and blanking timers.
// Optional fault latch/gate kill is compiled in when PWM_FAULT_EN is defined.
module pwm_multich_dt #(
    parameter int CNT_W    = 11,
    parameter int NCH      = 2,
    parameter int DEADTIME = 64,
    parameter int BLANK    = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    pwm_multich_dt_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W:0]   DT  = (CNT_W+1)'(DEADTIME);
    localparam int               BW  = $clog2(BLANK + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             synch_q;
    logic             at_max;
    logic             gate_ok;

    assign at_max        = (cnt_q == MAX);
    assign bus.PWM_synch = synch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            synch_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
            synch_q <= at_max;
        end
    end

`ifdef PWM_FAULT_EN
    logic [1:0] fsync_q;
    logic       lat_q;
    logic       en_q;
    logic       kill;

    // Gates die as soon as the synchronised fault is seen; they only come back on a period start.
    assign kill          = lat_q | ~fsync_q[1];
    assign gate_ok       = en_q & ~kill;
    assign bus.fault_lat = lat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsync_q <= 2'b11;
            lat_q   <= 1'b0;
            en_q    <= 1'b1;
        end else begin
            fsync_q <= {fsync_q[0], bus.fault_n};
            if (!fsync_q[1])
                lat_q <= 1'b1;
            else if (bus.fault_clr)
                lat_q <= 1'b0;
            if (kill)
                en_q <= 1'b0;
            else if (at_max)
                en_q <= 1'b1;
        end
    end
`else
    assign gate_ok = 1'b1;
`endif

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [CNT_W-1:0] shadow_q, active_q, duty_in;
        logic [CNT_W:0]   d_ext, cnt_ext;
        logic             pend_q, hi_q, lo_q, blank_q;
        logic             hi_d, lo_d, rise;
        logic [BW-1:0]    tmr_q, tmr_d;

        assign duty_in = bus.duty[gi*CNT_W +: CNT_W];
        assign d_ext   = {1'b0, active_q};
        assign cnt_ext = {1'b0, cnt_q};

        // Extra bit keeps D+DT from wrapping, so large duties simply never assert lo.
        assign hi_d  = gate_ok && (cnt_ext >= DT) && (cnt_ext < d_ext);
        assign lo_d  = gate_ok && (cnt_ext >= d_ext + DT);
        assign rise  = (hi_d & ~hi_q) | (lo_d & ~lo_q);
        assign tmr_d = rise ? BW'(BLANK) : ((tmr_q != '0) ? tmr_q - BW'(1) : '0);

        assign bus.duty_pend[gi]   = pend_q;
        assign bus.pwm_hi[gi]      = hi_q;
        assign bus.pwm_lo[gi]      = lo_q;
        assign bus.ovr_I_blank[gi] = blank_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_q <= '0;
                active_q <= '0;
                pend_q   <= 1'b0;
                hi_q     <= 1'b0;
                lo_q     <= 1'b0;
                tmr_q    <= '0;
                blank_q  <= 1'b0;
            end else begin
                if (bus.duty_wr[gi])
                    shadow_q <= duty_in;
                if (at_max) begin
                    if (bus.duty_wr[gi])
                        active_q <= duty_in;
                    else if (pend_q)
                        active_q <= shadow_q;
                    pend_q <= 1'b0;
                end else if (bus.duty_wr[gi]) begin
                    pend_q <= 1'b1;
                end
                hi_q    <= hi_d;
                lo_q    <= lo_d;
                tmr_q   <= tmr_d;
                blank_q <= (tmr_d != '0);
            end
        end
    end
endmodule

// File: tb/tb_pwm_multich_dt.sv
// Directed bench for pwm_multich_dt: per-cycle comparison against a period-level model plus literal pins.
module tb_pwm_multich_dt;
    localparam int CNT_W = 11;
    localparam int NCH   = 4;
    localparam int DT    = 64;
    localparam int BLANK = 128;
    localparam int PER   = 1 << CNT_W;
    localparam int MAX   = PER - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_multich_dt_if #(.CNT_W(CNT_W), .NCH(NCH)) bus ();

    pwm_multich_dt #(.CNT_W(CNT_W), .NCH(NCH), .DEADTIME(DT), .BLANK(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int     n_pass = 0;
    int     n_chk  = 0;
    bit     m_chk  = 1'b0;
    int     m_cnt;
    longint t;
    int     act [NCH];
    int     shd [NCH];
    bit     pend [NCH];
    bit     prev_hi [NCH];
    bit     prev_lo [NCH];
    bit     rose [NCH];
    longint last_rise [NCH];
    int     acc_hi [NCH], acc_lo [NCH], acc_bl [NCH];
    int     last_hi [NCH], last_lo [NCH], last_bl [NCH];

    task automatic chk(input string name, input int got, input int exp_v);
        n_chk++;
        if (got == exp_v) n_pass++;
        else $display("FAIL %s: got %0d required %0d at %0t", name, got, exp_v, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        t = 0;
        for (int k = 0; k < NCH; k++) begin
            act[k] = 0; shd[k] = 0; pend[k] = 0;
            prev_hi[k] = 0; prev_lo[k] = 0; rose[k] = 0; last_rise[k] = 0;
            acc_hi[k] = 0; acc_lo[k] = 0; acc_bl[k] = 0;
            last_hi[k] = -1; last_lo[k] = -1; last_bl[k] = -1;
        end
    endtask

    // One clock: gates in the sample after an edge reflect the counter value c seen at that edge.
    task automatic step();
        int c;
        logic [NCH-1:0] wr;
        logic [NCH*CNT_W-1:0] din;
        bit eh, el, eb;
        wr  = bus.duty_wr;
        din = bus.duty;
        c   = m_cnt;
        @(posedge clk);
        #1;
        t++;
        for (int k = 0; k < NCH; k++) begin
            eh = (c >= DT) && (c < act[k]);
            el = (c >= act[k] + DT);
            if ((eh && !prev_hi[k]) || (el && !prev_lo[k])) begin
                rose[k] = 1'b1;
                last_rise[k] = t;
            end
            eb = rose[k] && ((t - last_rise[k]) < BLANK);
            prev_hi[k] = eh;
            prev_lo[k] = el;
            if (wr[k]) shd[k] = int'(din[k*CNT_W +: CNT_W]);
            if (c == MAX) begin
                if (wr[k]) act[k] = shd[k];
                else if (pend[k]) act[k] = shd[k];
                pend[k] = 1'b0;
            end else if (wr[k]) begin
                pend[k] = 1'b1;
            end
            if (m_chk) begin
                chk($sformatf("hi%0d_c%0d", k, c), int'(bus.pwm_hi[k]), int'(eh));
                chk($sformatf("lo%0d_c%0d", k, c), int'(bus.pwm_lo[k]), int'(el));
                chk($sformatf("blank%0d_c%0d", k, c), int'(bus.ovr_I_blank[k]), int'(eb));
                chk($sformatf("pend%0d_c%0d", k, c), int'(bus.duty_pend[k]), int'(pend[k]));
            end
            if (c == 0) begin
                acc_hi[k] = 0; acc_lo[k] = 0; acc_bl[k] = 0;
            end
            acc_hi[k] += int'(bus.pwm_hi[k]);
            acc_lo[k] += int'(bus.pwm_lo[k]);
            acc_bl[k] += int'(bus.ovr_I_blank[k]);
            if (c == MAX) begin
                last_hi[k] = acc_hi[k]; last_lo[k] = acc_lo[k]; last_bl[k] = acc_bl[k];
            end
        end
        if (m_chk) chk($sformatf("synch_c%0d", c), int'(bus.PWM_synch), int'(c == MAX));
        m_cnt = (c + 1) % PER;
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (m_cnt != target && n < 3 * PER) begin
            step();
            n++;
        end
        if (m_cnt != target) chk("run_to_timeout", m_cnt, target);
    endtask

    task automatic set_duty(input int k, input int val);
        bus.duty[k*CNT_W +: CNT_W] = CNT_W'(val);
        bus.duty_wr[k] = 1'b1;
    endtask

    task automatic full_period();
        run_to(MAX);
        step();
    endtask

    task automatic chk_period(input string tag, input int k, input int hi, input int lo, input int bl);
        chk({tag, "_hi"}, last_hi[k], hi);
        chk({tag, "_lo"}, last_lo[k], lo);
        if (bl >= 0) chk({tag, "_blank"}, last_bl[k], bl);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hi"}, int'(bus.pwm_hi), 0);
        chk({tag, "_lo"}, int'(bus.pwm_lo), 0);
        chk({tag, "_pend"}, int'(bus.duty_pend), 0);
        chk({tag, "_synch"}, int'(bus.PWM_synch), 0);
        chk({tag, "_blank"}, int'(bus.ovr_I_blank), 0);
    endtask

    initial begin
        bus.duty    = '0;
        bus.duty_wr = '0;
`ifdef PWM_FAULT_EN
        bus.fault_n   = 1'b1;
        bus.fault_clr = 1'b0;
`endif
        model_reset();
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        m_chk = 1'b1;

        // Duty table: nominal, below dead time, beyond lo reach, retrigger spacing.
        run_to(100);
        set_duty(0, 'h200); set_duty(1, 'h030); set_duty(2, 'h7F0); set_duty(3, 74);
        step();
        bus.duty_wr = '0;
        $display("wr c=100 duty=200/030/7F0/04A pend=%b", bus.duty_pend);
        chk("pend_after_wr", int'(bus.duty_pend), 'hF);
        full_period();
        chk("pend_after_apply", int'(bus.duty_pend), 0);
        full_period();
        chk_period("ch0_200", 0, 448, 1472, 256);
        chk_period("ch1_030", 1, 0, 1936, 128);
        chk_period("ch2_7F0", 2, 1968, 0, 128);
        chk_period("ch3_04A", 3, 10, 1910, 202);

        // Mid-period write holds the old duty until the boundary.
        run_to(1000);
        set_duty(0, 'h300);
        step();
        bus.duty_wr = '0;
        $display("wr c=1000 ch0=300 pend=%b", bus.duty_pend);
        chk("pend_mid", int'(bus.duty_pend), 1);
        full_period();
        chk_period("ch0_old_hold", 0, 448, 1472, -1);
        chk("pend_cleared", int'(bus.duty_pend), 0);
        full_period();
        chk_period("ch0_300", 0, 704, 1216, -1);

        // Write landing on the MAX cycle goes straight to active.
        run_to(MAX);
        set_duty(1, 'h080);
        step();
        bus.duty_wr = '0;
        $display("wr c=MAX ch1=080 pend=%b", bus.duty_pend);
        chk("pend_max_wr", int'(bus.duty_pend), 0);
        run_to(MAX);
        step();
        chk_period("ch1_080", 1, 64, 1856, -1);
        chk_period("ch0_indep", 0, 704, 1216, -1);

        // Asynchronous reset mid-period, then a duty-0 period.
        run_to(500);
        #3 rst_n = 1'b0;
        #1;
        $display("async reset at c=500");
        chk_all_zero("mid_reset");
        model_reset();
        #2 rst_n = 1'b1;
        full_period();
        chk_period("post_rst_ch0", 0, 0, 1984, 128);
        chk_period("post_rst_ch3", 3, 0, 1984, 128);

`ifdef PWM_FAULT_EN
        run_to(10);
        set_duty(0, 'h200);
        step();
        bus.duty_wr = '0;
        full_period();
        run_to(300);
        m_chk = 1'b0;
        bus.fault_n = 1'b0;
        repeat (3) step();
        $display("fault at c=300 hi=%b lo=%b lat=%b", bus.pwm_hi, bus.pwm_lo, bus.fault_lat);
        chk("fault_hi", int'(bus.pwm_hi), 0);
        chk("fault_lo", int'(bus.pwm_lo), 0);
        chk("fault_lat_set", int'(bus.fault_lat), 1);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        repeat (4) step();
        chk("fault_clr_ignored", int'(bus.fault_lat), 1);
        bus.fault_n = 1'b1;
        repeat (4) step();
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        step();
        chk("fault_lat_clear", int'(bus.fault_lat), 0);
        run_to(MAX);
        chk("fault_hold_lo", int'(bus.pwm_lo), 0);
        step();
        chk("fault_synch", int'(bus.PWM_synch), 1);
        run_to(64);
        step();
        $display("resume c=64 hi=%b", bus.pwm_hi);
        chk("fault_resume_hi", int'(bus.pwm_hi[0]), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
